sprite_line_scan: RTL and testbench
===================================

# sprite_line_scan

Per-scanline sprite scheduler for the Aquarius+ video core. On each line-start pulse it sweeps all 64 entries of the sprite attribute RAM through the attribute RAM's read port and selects the sprites that intersect the requested line. It presents each hit, with row and tile index already resolved, to the sprite line renderer over a valid/ready stream. It is the sole driver of the attribute RAM's `spr_sel` read address.

## Interface
Parameters:
- `MAX_PER_LINE`, default 16: per-line hit limit; only used with `SPRSCAN_LIMIT_EN`.

Ports:
- `clk`  in  1  video clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `line_start`  in  1  one-cycle pulse that starts a scan.
- `line`  in  8  target scanline; sampled when `line_start` is high.
- `spr_sel`  out  6  attribute RAM read address.
- `spr_x` / `spr_y` / `spr_idx`  in  9/8/9  attribute fields for `spr_sel`; the read is combinational, same cycle.
- `spr_enable`, `spr_priority`, `spr_h16`, `spr_vflip`, `spr_hflip`  in  1 each.
- `spr_palette`  in  2  sprite palette select.
- `out_valid`  out  1  an output entry is present.
- `out_ready`  in  1  renderer accepts the entry.
- `out_x`  out  9  sprite X position.
- `out_idx`  out  9  resolved tile index.
- `out_row`  out  3  pixel row within the tile.
- `out_palette`  out  2  palette select.
- `out_priority`, `out_hflip`  out  1 each.
- `busy`  out  1  a scan is in progress.
- `done`  out  1  one-cycle pulse at the end of a scan.
- `overflow`  out  1  hit limit exceeded on the current line.

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE → SCAN on `line_start`. On entry: latch `line`, set `sel_r` = 0 and clear `overflow`.
- SCAN: one sprite is evaluated per cycle from the combinational attribute read at `spr_sel` = `sel_r`.
  - `row8 = (line_r − spr_y) mod 256`.
  - Hit when `spr_enable` && `row8 < (spr_h16 ? 16 : 8)`.
  - `r4 = spr_vflip ? ((spr_h16 ? 15 : 7) − row8[3:0]) : row8[3:0]`.
  - `out_idx = spr_idx + r4[3]`, 9-bit wrap, so 511+1 = 0.
  - `out_row = r4[2:0]`. `out_x`, `out_palette`, `out_priority` and `out_hflip` pass through.
  - Y wrap is intentional: `spr_y` = 250 with `h16` hits lines 250–255 and 0–9.
- Output stage is a single register.
  - The scanner advances `sel_r` only when the register is empty or being consumed (`out_valid && out_ready`).
  - On a hit the register is loaded; on a miss it is not.
  - Stall: `out_valid && !out_ready` holds `sel_r`, `spr_sel` and all `out_*` fields stable.
- After `sel_r` = 63 is evaluated, go to DRAIN. DRAIN waits until `out_valid` = 0, then pulses `done` and returns to IDLE.
- `busy` = 1 in SCAN and DRAIN.
- `line_start` while busy aborts and restarts: `out_valid` cleared the next cycle with the pending entry discarded, `sel_r` = 0, `line` relatched, no `done` for the aborted line.
- `line_start` coincident with the `done` cycle: `done` still pulses and the new scan begins.

## Timing
- Reset values: `spr_sel` = 0, `out_valid` = 0, all `out_*` fields = 0, `busy` = 0, `done` = 0, `overflow` = 0, state = IDLE.
- `line_start` at edge N: `busy` = 1 and `spr_sel` = 0 after edge N.
- The hit for sprite k appears on `out_*` one edge after `spr_sel` = k.
- With `out_ready` held high, a full scan is 64 evaluation cycles. `done` is high in cycle 65 after `line_start`, or one cycle later if the last sprite hit and must drain.
- `out_valid` drops only after a handshake (or on abort or reset). Fields never change while `out_valid && !out_ready`.

## Configuration
- `SPRSCAN_LIMIT_EN` defined:
  - Hits are counted per line. A hit found once the count equals `MAX_PER_LINE` is not emitted; it sets `overflow` and the scan goes straight to DRAIN.
  - `overflow` holds until the next `line_start` or reset.
- Undefined: every hit is emitted, `overflow` is tied to 0, and `MAX_PER_LINE` is ignored.

## Structure
- Shared package `sprscan_pkg`:
  - state encoding (IDLE/SCAN/DRAIN);
  - output entry struct {x[8:0], idx[8:0], row[2:0], palette[1:0], priority, hflip};
  - constants `NUM_SPRITES` = 64, `LINE_W` = 8.
- Sub-module `sprscan_eval`: combinational hit test and row/index resolution (`row8`, height compare, vflip, idx add).
- FSM, output register and counter live in `sprite_line_scan`.

## Test plan
- Single hit: sprite 5 {enable, y = 100, h16 = 0, idx = 0x40, x = 300}, line = 103, `out_ready` = 1 → exactly one entry {x = 300, idx = 0x40, row = 3}; `done` in cycle 65.
- 16-high with vflip: y = 250, h16, vflip, idx = 511, line = 2 → `row8` = 8, `r4` = 7, entry {idx = 511, row = 7}; line = 254 → `row8` = 4, `r4` = 11, entry {idx = 0, row = 3}.
- Backpressure: sprites 0–3 all hit, `out_ready` toggled 1-0-0-1 → four entries in order 0, 1, 2, 3; fields stable during stalls; `spr_sel` frozen during stalls.
- Disabled and miss: all sprites have enable = 0 except sprite 63, which has y = line + 1 → no entries; `done` at cycle 65.
- Abort: `line_start` at cycle 20 of a scan with `out_valid` = 1 → entry dropped, `spr_sel` = 0 next cycle, single `done` for the new line only.
- Limit (`SPRSCAN_LIMIT_EN`, `MAX_PER_LINE` = 16): 20 hits on a line → 16 entries, `overflow` = 1, `done` pulses; next `line_start` clears `overflow`.

Source files
------------

// File: rtl/sprscan_pkg.sv
// sprscan_pkg: shared types and constants for the per-scanline sprite scheduler.
package sprscan_pkg;
  localparam int NUM_SPRITES = 64;
  localparam int LINE_W = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN} state_e;
  typedef struct packed {
    logic [8:0] x;
    logic [8:0] idx;
    logic [2:0] row;
    logic [1:0] palette;
    logic       prio;
    logic       hflip;
  } entry_t;
endpackage

// File: rtl/sprscan_eval.sv
// sprscan_eval: combinational hit test and row/tile-index resolution for one sprite.
import sprscan_pkg::*;
module sprscan_eval (
  input  logic [LINE_W-1:0] line_i,
  input  logic [7:0]        spr_y_i,
  input  logic [8:0]        spr_idx_i,
  input  logic              spr_enable_i,
  input  logic              spr_h16_i,
  input  logic              spr_vflip_i,
  output logic              hit_o,
  output logic [8:0]        idx_o,
  output logic [2:0]        row_o
);
  logic [7:0] row8;
  logic [3:0] r4;
  always_comb begin
    row8 = line_i - spr_y_i;
    hit_o = spr_enable_i && row8 < (spr_h16_i ? 8'd16 : 8'd8);
    r4 = spr_vflip_i ? (spr_h16_i ? 4'd15 : 4'd7) - row8[3:0] : row8[3:0];
    idx_o = spr_idx_i + 9'(r4[3]);
    row_o = r4[2:0];
  end
endmodule

// File: rtl/sprite_line_scan.sv
// sprite_line_scan: sweeps the 64-entry attribute RAM each line and streams hits to the renderer.
// Optional per-line hit limit enabled by defining SPRSCAN_LIMIT_EN.
import sprscan_pkg::*;
module sprite_line_scan #(
  parameter int MAX_PER_LINE = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              line_start,
  input  logic [LINE_W-1:0] line,
  output logic [5:0]        spr_sel,
  input  logic [8:0]        spr_x,
  input  logic [7:0]        spr_y,
  input  logic [8:0]        spr_idx,
  input  logic              spr_enable,
  input  logic              spr_priority,
  input  logic              spr_h16,
  input  logic              spr_vflip,
  input  logic              spr_hflip,
  input  logic [1:0]        spr_palette,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8:0]        out_x,
  output logic [8:0]        out_idx,
  output logic [2:0]        out_row,
  output logic [1:0]        out_palette,
  output logic              out_priority,
  output logic              out_hflip,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
`ifdef SPRSCAN_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  localparam int CNT_W = $clog2(MAX_PER_LINE + 2);
  state_e            state_q, state_d;
  logic [5:0]        sel_q, sel_d;
  logic [LINE_W-1:0] line_q, line_d;
  entry_t            out_q, out_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hit, full;
  logic [8:0]        ev_idx;
  logic [2:0]        ev_row;
  sprscan_eval u_eval (
    .line_i       (line_q),
    .spr_y_i      (spr_y),
    .spr_idx_i    (spr_idx),
    .spr_enable_i (spr_enable),
    .spr_h16_i    (spr_h16),
    .spr_vflip_i  (spr_vflip),
    .hit_o        (hit),
    .idx_o        (ev_idx),
    .row_o        (ev_row)
  );
  // Without the limit build, full is constant 0 so the counter and overflow flag fold away.
  assign full = LIMIT_EN && cnt_q == CNT_W'(MAX_PER_LINE);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sel_q <= '0;
      line_q <= '0;
      out_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      line_q <= line_d;
      out_q <= out_d;
      valid_q <= valid_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    line_d = line_q;
    out_d = out_q;
    valid_d = valid_q && !out_ready;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    done = state_q == ST_DRAIN && !valid_q;
    if (line_start) begin
      state_d = ST_SCAN;
      sel_d = '0;
      line_d = line;
      valid_d = 1'b0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (state_q == ST_SCAN && (!valid_q || out_ready)) begin
      sel_d = sel_q + 6'd1;
      state_d = sel_q == 6'(NUM_SPRITES - 1) ? ST_DRAIN : ST_SCAN;
      if (hit && full) begin
        ovf_d = 1'b1;
        state_d = ST_DRAIN;
      end else if (hit) begin
        out_d = '{x: spr_x, idx: ev_idx, row: ev_row, palette: spr_palette,
                  prio: spr_priority, hflip: spr_hflip};
        valid_d = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (done) begin
      state_d = ST_IDLE;
    end
  end
  assign spr_sel = sel_q;
  assign out_valid = valid_q;
  assign out_x = out_q.x;
  assign out_idx = out_q.idx;
  assign out_row = out_q.row;
  assign out_palette = out_q.palette;
  assign out_priority = out_q.prio;
  assign out_hflip = out_q.hflip;
  assign busy = state_q != ST_IDLE;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_sprite_line_scan.sv
// tb_sprite_line_scan: directed self-checking bench with a behavioural attribute RAM.
module tb_sprite_line_scan;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       line_start = 1'b0;
  logic [7:0] line = '0;
  logic [5:0] spr_sel;
  logic [8:0] spr_x, spr_idx, out_x, out_idx;
  logic [7:0] spr_y;
  logic       spr_enable, spr_priority, spr_h16, spr_vflip, spr_hflip;
  logic [1:0] spr_palette, out_palette;
  logic       out_valid, out_ready = 1'b1;
  logic [2:0] out_row;
  logic       out_priority, out_hflip, busy, done, overflow;
  logic [8:0] ax[64], ai[64];
  logic [7:0] ay[64];
  logic [1:0] ap[64];
  logic       ae[64], apr[64], ah[64], av[64], ahf[64];
  logic [24:0] q[$];
  int n_assert = 0, n_fail = 0, n_done = 0, cyc, first_v;
`ifdef SPRSCAN_LIMIT_EN
  localparam int EXP_N = 16;
  localparam bit EXP_O = 1'b1;
`else
  localparam int EXP_N = 20;
  localparam bit EXP_O = 1'b0;
`endif
  always #5 clk = ~clk;
  assign spr_x = ax[spr_sel];
  assign spr_y = ay[spr_sel];
  assign spr_idx = ai[spr_sel];
  assign spr_enable = ae[spr_sel];
  assign spr_priority = apr[spr_sel];
  assign spr_h16 = ah[spr_sel];
  assign spr_vflip = av[spr_sel];
  assign spr_hflip = ahf[spr_sel];
  assign spr_palette = ap[spr_sel];
  sprite_line_scan #(.MAX_PER_LINE(16)) dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .line(line), .spr_sel(spr_sel),
    .spr_x(spr_x), .spr_y(spr_y), .spr_idx(spr_idx), .spr_enable(spr_enable),
    .spr_priority(spr_priority), .spr_h16(spr_h16), .spr_vflip(spr_vflip), .spr_hflip(spr_hflip),
    .spr_palette(spr_palette), .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_idx(out_idx), .out_row(out_row), .out_palette(out_palette), .out_priority(out_priority),
    .out_hflip(out_hflip), .busy(busy), .done(done), .overflow(overflow)
  );
  always @(posedge clk) begin
    if (reset_n && out_valid && out_ready)
      q.push_back({out_x, out_idx, out_row, out_palette, out_priority, out_hflip});
    if (reset_n && done) n_done++;
  end
  function automatic logic [24:0] ent(int x, int idx, int row, int pal, int pri, int hf);
    return {9'(x), 9'(idx), 3'(row), 2'(pal), 1'(pri), 1'(hf)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_ram();
    for (int i = 0; i < 64; i++) begin
      ax[i] = '0; ay[i] = '0; ai[i] = '0; ap[i] = '0;
      ae[i] = 1'b0; apr[i] = 1'b0; ah[i] = 1'b0; av[i] = 1'b0; ahf[i] = 1'b0;
    end
    q.delete();
    n_done = 0;
  endtask
  task automatic start(input logic [7:0] l);
    line_start = 1'b1;
    line = l;
    tick();
    line_start = 1'b0;
  endtask
  task automatic wait_done();
    cyc = 1;
    first_v = 0;
    while (!done && cyc < 300) begin
      if (out_valid && first_v == 0) first_v = cyc;
      tick();
      cyc++;
    end
    tick();
  endtask
  initial begin
    clear_ram();
    tick();
    tick();
    chk("rst_spr_sel", spr_sel, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_fields", {out_x, out_idx, out_row, out_palette, out_priority, out_hflip}, 0);
    reset_n = 1'b1;
    tick();
    // single hit on sprite 5
    ae[5] = 1; ay[5] = 100; ai[5] = 9'h40; ax[5] = 300; ap[5] = 2; apr[5] = 1; ahf[5] = 1;
    start(103);
    chk("start_busy", busy, 1);
    chk("start_sel", spr_sel, 0);
    wait_done();
    chk("single_first_valid_cycle", first_v, 7);
    chk("single_done_cycle", cyc, 65);
    chk("single_count", q.size(), 1);
    chk("single_entry", q[0], ent(300, 9'h40, 3, 2, 1, 1));
    chk("single_ndone", n_done, 1);
    chk("idle_busy", busy, 0);
    // 16-high vflip with index carry
    clear_ram();
    ae[10] = 1; ay[10] = 250; ah[10] = 1; av[10] = 1; ai[10] = 511; ax[10] = 5;
    start(2);
    wait_done();
    chk("vflip_a_count", q.size(), 1);
    chk("vflip_a_entry", q[0], ent(5, 511, 7, 0, 0, 0));
    q.delete();
    start(254);
    wait_done();
    chk("vflip_b_count", q.size(), 1);
    chk("vflip_b_entry", q[0], ent(5, 0, 3, 0, 0, 0));
    // backpressure on four consecutive hits
    clear_ram();
    for (int i = 0; i < 4; i++) begin
      ae[i] = 1; ay[i] = 50; ai[i] = 9'(9'h10 + i); ax[i] = 9'(100 + i);
    end
    out_ready = 1'b0;
    start(50);
    tick();
    chk("bp_valid", out_valid, 1);
    chk("bp_idx", out_idx, 9'h10);
    chk("bp_sel", spr_sel, 1);
    for (int s = 0; s < 2; s++) begin
      tick();
      chk("bp_stall_valid", out_valid, 1);
      chk("bp_stall_idx", out_idx, 9'h10);
      chk("bp_stall_x", out_x, 100);
      chk("bp_stall_sel", spr_sel, 1);
    end
    out_ready = 1'b1;
    wait_done();
    chk("bp_count", q.size(), 4);
    for (int i = 0; i < 4; i++) chk("bp_order", q[i], ent(100 + i, 16 + i, 0, 0, 0, 0));
    // disabled sprites plus a near-miss on sprite 63
    clear_ram();
    ae[63] = 1; ay[63] = 41;
    start(40);
    wait_done();
    chk("miss_count", q.size(), 0);
    chk("miss_done_cycle", cyc, 65);
    chk("miss_ndone", n_done, 1);
    // abort with a pending entry held by backpressure
    clear_ram();
    ae[18] = 1; ay[18] = 60; ai[18] = 9'h55; ax[18] = 7;
    ae[30] = 1; ay[30] = 70; ai[30] = 9'h66; ax[30] = 9;
    out_ready = 1'b0;
    start(60);
    for (int i = 1; i < 20; i++) tick();
    chk("abort_pending_valid", out_valid, 1);
    chk("abort_pending_idx", out_idx, 9'h55);
    start(70);
    out_ready = 1'b1;
    chk("abort_valid_clr", out_valid, 0);
    chk("abort_sel", spr_sel, 0);
    chk("abort_busy", busy, 1);
    wait_done();
    chk("abort_done_cycle", cyc, 65);
    chk("abort_count", q.size(), 1);
    chk("abort_entry", q[0], ent(9, 9'h66, 0, 0, 0, 0));
    chk("abort_ndone", n_done, 1);
    // twenty hits on one line against the per-line limit
    clear_ram();
    for (int i = 0; i < 20; i++) begin
      ae[i] = 1; ay[i] = 80; ai[i] = 9'(i); ax[i] = 9'(i);
    end
    start(80);
    wait_done();
    chk("limit_count", q.size(), EXP_N);
    chk("limit_last", q[EXP_N - 1], ent(EXP_N - 1, EXP_N - 1, 0, 0, 0, 0));
    chk("limit_overflow", overflow, EXP_O);
    chk("limit_ndone", n_done, 1);
    start(200);
    chk("limit_ovf_clear", overflow, 0);
    wait_done();
    chk("limit_next_done_cycle", cyc, 65);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
